stream_dest_router: RTL
=======================

Name: stream_dest_router

Overview:
- Egress-side counterpart of the crossbar's packet arbiter: takes one AXI-Stream-style input and steers each packet to one of NUM_MASTER outputs, selected by the TDEST carried on the packet's head beat.
- Route is locked from head beat to the TLAST beat, so packets are never interleaved on an output.
- Packets addressed to a non-existent output are consumed and discarded, and counted.
- A 2-entry skid buffer registers all outputs and s_ready_o while keeping full throughput.

Parameters:
- NUM_MASTER, 4, number of output ports (2..16, need not be a power of two).
- DATA_WIDTH, 32, TDATA width in bits.
- DEST_WIDTH, localparam = max(1, $clog2(NUM_MASTER)), TDEST width.
- CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_data_i  input  DATA_WIDTH  input beat data.
- s_valid_i  input  1  input beat valid.
- s_last_i  input  1  input beat is last of packet.
- s_dest_i  input  DEST_WIDTH  destination; sampled only on head beats.
- s_ready_o  output  1  input ready (registered).
- m_data_o  output  NUM_MASTER*DATA_WIDTH  per-port data, port k at [k*DATA_WIDTH +: DATA_WIDTH]; all ports carry the same head-of-buffer data.
- m_valid_o  output  NUM_MASTER  one-hot or zero; only the routed port is asserted.
- m_last_o  output  NUM_MASTER  per-port last; meaningful only where m_valid_o is set.
- m_ready_i  input  NUM_MASTER  per-port ready.
- drop_o  output  1  one-cycle pulse when the head beat of a dropped packet is accepted.
- drop_cnt_o  output  CNT_WIDTH  dropped-packet count, saturates at all-ones.

Behaviour:
- Reset (async assert, sync-release assumed upstream):
  - state = HEAD; skid buffer empty.
  - s_ready_o = 1; m_valid_o = 0; m_last_o = 0; m_data_o = 0.
  - drop_o = 0; drop_cnt_o = 0.
- Input accept: beat is accepted when s_valid_i && s_ready_o.
  - s_ready_o = !(buffer holds 2 entries), registered.
  - s_valid_i/s_data_i must be stable while valid && !ready; this is a bench check only.
- FSM (advances only on accepted beats):
  - HEAD, dest < NUM_MASTER:
    - route_q <= s_dest_i; beat pushed with tag s_dest_i.
    - s_last_i = 1 (single-beat packet): stay in HEAD.
    - otherwise: go to BODY.
  - HEAD, dest >= NUM_MASTER:
    - beat discarded, not pushed.
    - drop_o pulses the next cycle; drop_cnt_o increments (saturating).
    - s_last_i = 1: stay in HEAD; otherwise go to DROP.
  - BODY: beat pushed with tag route_q; s_dest_i is ignored; s_last_i = 1 returns to HEAD.
  - DROP: beat discarded; s_last_i = 1 returns to HEAD.
  - Back-to-back packets: the beat after a last beat is a head beat, with no idle cycle required.
- Skid buffer:
  - Entries hold {data, last, tag}; FIFO order; output entry = oldest.
  - m_valid_o[k] = buffer non-empty && tag == k.
  - Pop when m_ready_i[tag] && m_valid_o[tag]; m_ready_i of non-selected ports is ignored.
  - Simultaneous push and pop: occupancy unchanged, and the order is preserved.
  - Latency: an accepted beat appears at the output 1 cycle later if the buffer was empty.
  - Sustained throughput is 1 beat/cycle when the routed port holds m_ready_i = 1.
- Head-of-line blocking: a stalled destination blocks all subsequent packets, including packets to other ports. This is intended; per-port queues are out of scope.
- Reset mid-packet: in-flight beats are lost and the FSM returns to HEAD. The next accepted beat is treated as a head beat.
- Drops never appear on any m_valid_o; a dropped packet's beats are accepted at 1 beat/cycle regardless of m_ready_i.

Decomposition:
- Shared package stream_xbar_pkg: enum route_state_e {HEAD, BODY, DROP}, a dest_width() function, and the default DATA_WIDTH/NUM_MASTER constants shared with the arbiter.
- One sub-module, stream_skid_buffer: 2-entry registered valid/ready slice, parameterised on payload width.
  - Router instantiates it with payload DATA_WIDTH+1+DEST_WIDTH.
  - The arbiter side can reuse it.

Test Plan:
- 3-beat packet, dest=2, data 0xA0..0xA2, all m_ready_i=1 -> m_valid_o=4'b0100 on 3 consecutive cycles starting 1 cycle after the first accept; m_last_o[2] on 0xA2; drop_cnt_o=0.
- Back-to-back: 1-beat packet dest=1, then 2-beat packet dest=3, with s_dest_i changed to 0 mid-packet -> outputs 0010, 1000, 1000 on consecutive cycles; the mid-packet dest change is ignored; s_ready_o is never deasserted.
- NUM_MASTER=3: 4-beat packet with dest=3 -> no m_valid_o, 4 beats accepted in 4 cycles, drop_o pulses once, drop_cnt_o=1; a following packet to dest=0 routes normally.
- Backpressure: dest=0 stream of 6 beats with m_ready_i[0]=0 for cycles 2..5 -> s_ready_o drops after 2 buffered beats; no beat lost or duplicated, order 0..5 preserved; m_ready_i[1]=1 throughout has no effect.
- Saturation: CNT_WIDTH=2, five single-beat packets to an invalid dest -> drop_cnt_o goes 1, 2, 3, 3, 3.
- Async reset asserted mid-packet (beat 2 of 4, dest=1, buffer full) -> within the same cycle m_valid_o=0 and s_ready_o=1. After release, the next beat with dest=2 routes to port 2.

Source files
------------

// File: rtl/stream_xbar_pkg.sv
// Types and constants shared by the stream crossbar blocks (dest router, packet arbiter).
package stream_xbar_pkg;

    localparam int DEFAULT_NUM_MASTER = 4;
    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        HEAD,
        BODY,
        DROP
    } route_state_e;

    // TDEST width for a given port count; never narrower than one bit.
    function automatic int dest_width(input int num_master);
        return (num_master > 2) ? $clog2(num_master) : 1;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry registered valid/ready slice: full throughput with in_ready and all outputs driven from flops.
module stream_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic             head_vld_q;
    logic             tail_vld_q;
    logic             push;
    logic             pop;

    assign push = in_valid && !tail_vld_q;
    assign pop  = head_vld_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: payload registers are reset too so the outputs read zero out of reset.
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
        end else begin
            if (!head_vld_q) begin
                if (push) begin
                    head_q     <= in_data;
                    head_vld_q <= 1'b1;
                end
            end else if (!tail_vld_q) begin
                if (pop && push) begin
                    head_q <= in_data;
                end else if (pop) begin
                    head_vld_q <= 1'b0;
                end else if (push) begin
                    tail_q     <= in_data;
                    tail_vld_q <= 1'b1;
                end
            end else if (pop) begin
                // Full: no push possible, the skid entry moves up to the head.
                head_q     <= tail_q;
                tail_vld_q <= 1'b0;
            end
        end
    end

    assign in_ready  = !tail_vld_q;
    assign out_valid = head_vld_q;
    assign out_data  = head_q;

endmodule

// File: rtl/stream_dest_router.sv
// Steers each input packet to one of NUM_MASTER outputs by the TDEST of its head beat;
// packets to non-existent outputs are swallowed and counted.
module stream_dest_router
    import stream_xbar_pkg::*;
#(
    parameter int  NUM_MASTER = DEFAULT_NUM_MASTER,
    parameter int  DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int  CNT_WIDTH  = 8,
    localparam int DEST_WIDTH = dest_width(NUM_MASTER)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [DATA_WIDTH-1:0]            s_data_i,
    input  logic                             s_valid_i,
    input  logic                             s_last_i,
    input  logic [DEST_WIDTH-1:0]            s_dest_i,
    output logic                             s_ready_o,
    output logic [NUM_MASTER*DATA_WIDTH-1:0] m_data_o,
    output logic [NUM_MASTER-1:0]            m_valid_o,
    output logic [NUM_MASTER-1:0]            m_last_o,
    input  logic [NUM_MASTER-1:0]            m_ready_i,
    output logic                             drop_o,
    output logic [CNT_WIDTH-1:0]             drop_cnt_o
);

    localparam int PAYLOAD_WIDTH = DATA_WIDTH + 1 + DEST_WIDTH;

    route_state_e             state_q;
    logic [DEST_WIDTH-1:0]    route_q;
    logic                     dest_ok;
    logic                     accept;
    logic                     head_drop;
    logic [DEST_WIDTH-1:0]    push_tag;
    logic                     buf_in_valid;
    logic [PAYLOAD_WIDTH-1:0] buf_in;
    logic [PAYLOAD_WIDTH-1:0] buf_out;
    logic                     buf_out_valid;
    logic                     buf_out_ready;
    logic [DATA_WIDTH-1:0]    out_data;
    logic                     out_last;
    logic [DEST_WIDTH-1:0]    out_tag;

    // With a power-of-two port count every encodable dest exists.
    generate
        if ((1 << DEST_WIDTH) > NUM_MASTER) begin : g_dest_check
            assign dest_ok = s_dest_i < DEST_WIDTH'(NUM_MASTER);
        end else begin : g_dest_all
            assign dest_ok = 1'b1;
        end
    endgenerate

    assign accept       = s_valid_i && s_ready_o;
    assign head_drop    = accept && (state_q == HEAD) && !dest_ok;
    assign push_tag     = (state_q == BODY) ? route_q : s_dest_i;
    assign buf_in_valid = s_valid_i && (((state_q == HEAD) && dest_ok) || (state_q == BODY));
    assign buf_in       = {s_data_i, s_last_i, push_tag};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HEAD;
            route_q    <= '0;
            drop_o     <= 1'b0;
            drop_cnt_o <= '0;
        end else begin
            drop_o <= head_drop;
            if (head_drop && (drop_cnt_o != '1)) begin
                drop_cnt_o <= drop_cnt_o + 1'b1;
            end
            if (accept) begin
                unique case (state_q)
                    HEAD: begin
                        if (dest_ok) begin
                            route_q <= s_dest_i;
                            if (!s_last_i) state_q <= BODY;
                        end else if (!s_last_i) begin
                            state_q <= DROP;
                        end
                    end
                    BODY, DROP: begin
                        if (s_last_i) state_q <= HEAD;
                    end
                    default: state_q <= HEAD;
                endcase
            end
        end
    end

    stream_skid_buffer #(
        .WIDTH (PAYLOAD_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_data   (buf_in),
        .in_valid  (buf_in_valid),
        .in_ready  (s_ready_o),
        .out_data  (buf_out),
        .out_valid (buf_out_valid),
        .out_ready (buf_out_ready)
    );

    assign {out_data, out_last, out_tag} = buf_out;

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        m_valid_o = '0;
        m_last_o  = '0;
        for (int k = 0; k < NUM_MASTER; k++) begin
            m_valid_o[k] = buf_out_valid && (out_tag == DEST_WIDTH'(k));
            m_last_o[k]  = m_valid_o[k] && out_last;
        end
    end

    // Only the routed port's ready can pop the head entry.
    assign buf_out_ready = |(m_valid_o & m_ready_i);
    assign m_data_o      = {NUM_MASTER{out_data}};

endmodule
